// File: rtl/fmrv32im_conv33_acc.sv
// fmrv32im_conv33_acc
// ---------------------------------------------------------------------------
// Sums ROWS signed row partial sums (from an upstream 3-term multiply-add)
// into one output pixel. The sum is arithmetically shifted right and then
// clamped to an unsigned 8-bit pixel.
//
// Handshakes:
//   - Input side: IN_VALID is a strobe, and there is no back-pressure.
//     A strobe is consumed only in ACC. A strobe in IDLE or OUT is
//     discarded and pulses DROP for one cycle.
//   - Output side: valid/ready. OUT_VALID comes only from the state
//     register. Once it is raised, it stays high until a cycle with
//     OUT_READY=1. OUT_DATA and OUT_SAT do not change while it is high.
//     A transfer happens on a rising edge where OUT_VALID=1 and
//     OUT_READY=1.
//
// Ports:
//   CLK        system clock. All state changes on its rising edge.
//   RST        asynchronous, active-high reset.
//   START      pulse that opens a new pixel. SHIFT is latched with it.
//   SHIFT      arithmetic right-shift amount (0..31).
//   IN_VALID   partial-sum strobe.
//   IN_DATA    signed 32-bit row partial sum.
//   OUT_READY  consumer accepts the pixel.
//   OUT_VALID  pixel result valid.
//   OUT_DATA   saturated unsigned pixel.
//   OUT_SAT    the pixel was clamped.
//   BUSY       high in ACC and OUT.
//   DROP       one-cycle pulse after a strobe arrives outside ACC.
//   DBG_STATE  current FSM state (IDLE=0, ACC=1, OUT=2), for observation.
// ---------------------------------------------------------------------------
module fmrv32im_conv33_acc #(
  parameter int ROWS = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [4:0]  SHIFT,
  input  logic        IN_VALID,
  input  logic [31:0] IN_DATA,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_SAT,
  output logic        BUSY,
  output logic        DROP,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  state_t             state;
  logic signed [33:0] acc;
  logic [1:0]         row_cnt;
  logic [4:0]         shift_q;
  logic [7:0]         data_q;
  logic               sat_q;
  logic               drop_q;

  // The pixel is formed from the running sum plus the final partial sum.
  // It is formed in the same cycle as that strobe, so the result is
  // registered one cycle after the last strobe. With 34 bits, four
  // full-scale 32-bit terms cannot wrap.
  logic signed [33:0] sum;
  logic signed [33:0] shifted;
  logic [7:0]         pix_data;
  logic               pix_sat;

  always_comb begin
    sum      = acc + {{2{IN_DATA[31]}}, IN_DATA};
    shifted  = sum >>> shift_q;
    pix_data = shifted[7:0];
    pix_sat  = 1'b0;
    if (shifted[33]) begin
      pix_data = 8'd0;
      pix_sat  = 1'b1;
    end else if (|shifted[32:8]) begin
      pix_data = 8'd255;
      pix_sat  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      acc     <= '0;
      row_cnt <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (IN_VALID) drop_q <= 1'b1;
          if (START) begin
            acc     <= '0;
            row_cnt <= '0;
            shift_q <= SHIFT;
            state   <= ACC;
          end
        end
        ACC: begin
          // START takes priority and abandons the partial pixel. A strobe
          // in the same cycle belongs to the abandoned pixel and is not
          // added.
          if (START) begin
            acc     <= '0;
            row_cnt <= '0;
            shift_q <= SHIFT;
          end else if (IN_VALID) begin
            if (row_cnt == LAST_ROW) begin
              data_q <= pix_data;
              sat_q  <= pix_sat;
              state  <= OUT;
            end else begin
              acc     <= sum;
              row_cnt <= row_cnt + 2'd1;
            end
          end
        end
        OUT: begin
          if (IN_VALID) drop_q <= 1'b1;
          // START is only honoured together with a completed transfer.
          if (OUT_READY) begin
            if (START) begin
              acc     <= '0;
              row_cnt <= '0;
              shift_q <= SHIFT;
              state   <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // These outputs are decoded from registers only. They follow reset at
  // once and never depend on OUT_READY.
  assign OUT_VALID = (state == OUT);
  assign BUSY      = (state != IDLE);
  assign OUT_DATA  = data_q;
  assign OUT_SAT   = sat_q;
  assign DROP      = drop_q;
  assign DBG_STATE = state;

endmodule
